fir_sample_feeder: RTL and testbench
====================================

Name: fir_sample_feeder

Overview:
Source-side end of the FIR sample interface. It accepts samples from an upstream writer over a valid/ready handshake and buffers them in a small FIFO. It then drives them onto the FIR sample input, one per programmable sample strobe. It sits directly upstream of the pipelined FIR MAC and decouples bursty producers from the filter's fixed sample cadence.

Parameters:
Sample_size, 6, sample width in bits; matches the FIR sample input.
FIFO_depth, 8, buffer entries; power of two.
addr_size, 3, log2(FIFO_depth).
Prime_level, 4, FIFO occupancy required before streaming starts; 1..FIFO_depth.
div_size, 4, width of the rate divider control.

Ports:
clock  input  1  system clock; all logic is on the rising edge.
reset  input  1  synchronous, active-high reset.
in_data  input  Sample_size  upstream sample.
in_valid  input  1  upstream sample present.
in_ready  output  1  feeder can accept; equals (fifo_count != FIFO_depth).
run  input  1  enable streaming; level-sensitive.
rate_div  input  div_size  strobe period minus 1; sampled only while in IDLE.
Sample_out  output  Sample_size  sample presented to the FIR; registered.
sample_strobe  output  1  one-cycle pulse; Sample_out is new this cycle.
underrun  output  1  sticky flag; a strobe found the FIFO empty.
fifo_count  output  addr_size+1  current occupancy, 0..FIFO_depth.

Behaviour:
- Reset (synchronous, active-high) values:
  - Sample_out=0, sample_strobe=0, underrun=0, fifo_count=0, in_ready=1, state=IDLE.
  - Read/write pointers and the divider counter are 0.
  - Reset mid-operation discards all buffered data.
- Push: accepted when in_valid && in_ready; write at wr_ptr; pointer wraps modulo FIFO_depth.
  - in_ready derives from the registered count, so a pop in the same cycle never enables a push into a full FIFO.
  - Push is allowed in every state.
- FSM states: IDLE, PRIME, STREAM.
  - IDLE: no strobes. Sample_out holds its last value.
    - rate_div is latched into div_reg on the IDLE->PRIME transition.
    - run=1 -> PRIME; underrun is cleared on this transition.
  - PRIME: no strobes.
    - fifo_count >= Prime_level -> STREAM; the divider counter is loaded with 0.
    - run=0 -> IDLE.
  - STREAM: the divider counts 0..div_reg.
    - Strobe fires the cycle after the counter equals div_reg, then the counter returns to 0.
    - The first strobe fires exactly div_reg+1 cycles after entering STREAM.
    - run=0 -> IDLE immediately; a strobe pending on that edge is suppressed.
- On strobe:
  - If fifo_count>0: pop the head; Sample_out=head; sample_strobe=1 in the same registered cycle.
  - If fifo_count==0: Sample_out=0; sample_strobe=1; underrun set. The FSM stays in STREAM (zero-stuffing keeps the FIR cadence).
- Push and pop in the same cycle: count unchanged; both pointers advance.
  - With an empty FIFO there is no bypass: a simultaneous push+strobe is an underrun, and the pushed sample stays buffered.
- rate_div=0 gives a strobe every cycle. Throughput matches the FIR's one-sample-per-clock rate.
- fifo_count never exceeds FIFO_depth and never goes negative. Pointer wrap is checked at entry FIFO_depth-1 -> 0.

Decomposition:
- Shared package/include:
  - FSM state encodings (IDLE=2'd0, PRIME=2'd1, STREAM=2'd2).
  - Default Sample_size shared with the FIR MAC.
- One natural sub-module: fir_feeder_fifo.
  - Synchronous FIFO providing storage, pointers, count, full, and empty.
  - Parameters: Sample_size, FIFO_depth, addr_size.
  - The parent holds the FSM, the divider, and the output registers.

Test Plan:
- Reset check: assert reset mid-stream with 5 entries buffered -> next cycle fifo_count=0, Sample_out=0, sample_strobe=0, underrun=0, in_ready=1.
- Prime and latency:
  - Stimulus: rate_div=2, run=1, push 1,2,3,4 back-to-back.
  - Required: STREAM is entered the cycle after count reaches 4; strobes every 3 cycles, with the first 3 cycles after entry; Sample_out sequence 1,2,3,4.
- Full boundary:
  - Stimulus: push 9 samples with run=0.
  - Required: in_ready drops after the 8th; the 9th is held off with fifo_count=8.
  - Then run=1, rate_div=0 -> eight consecutive strobes with in-order data, then in_ready=1.
- Underrun:
  - Stimulus: rate_div=0, prime 4 samples (10,11,12,13), no more pushes.
  - Required: strobes 5..7 give Sample_out=0; underrun=1 from strobe 5 and stays set.
  - run 0->1 clears underrun on the IDLE->PRIME transition.
- Simultaneous push/pop with rate_div=0 and count=3 -> count stays 3 over 20 cycles; pointers wrap; data stays in order.
- Stop mid-stream: drop run with 3 entries left -> no further strobes; entries are retained; the next run resumes with the oldest entry.

Source files
------------

// File: rtl/fir_sample_feeder_pkg.sv
// Shared definitions for the FIR sample feeder and its neighbours.
// Holds the feeder FSM encoding and the sample width common with the FIR MAC.
package fir_sample_feeder_pkg;

  localparam int FIR_SAMPLE_SIZE = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    STREAM = 2'd2
  } feeder_state_t;

endpackage

// File: rtl/fir_feeder_fifo.sv
// Synchronous FIFO for the sample feeder; head is visible combinationally, count/full/empty registered.
// Push into full and pop from empty are ignored; a same-cycle push+pop keeps the count steady.
module fir_feeder_fifo
  import fir_sample_feeder_pkg::*;
#(
  parameter int Sample_size = FIR_SAMPLE_SIZE,
  parameter int FIFO_depth  = 8,
  parameter int addr_size   = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic [Sample_size-1:0] push_data,
  input  logic                   pop,
  output logic [Sample_size-1:0] head,
  output logic [addr_size:0]     count,
  output logic                   full,
  output logic                   empty
);

  localparam logic [addr_size:0] DEPTH = (addr_size + 1)'(FIFO_depth);

  logic [Sample_size-1:0] mem [FIFO_depth];
  logic [addr_size-1:0]   wr_ptr;
  logic [addr_size-1:0]   rd_ptr;
  logic                   do_push;
  logic                   do_pop;

  assign full    = (count == DEPTH);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fir_sample_feeder.sv
// Buffers upstream samples and presents one to the FIR per programmable strobe, zero-stuffing on underrun.
// Strobe period is rate_div+1 cycles; upstream is held off only while the FIFO is full.
module fir_sample_feeder
  import fir_sample_feeder_pkg::*;
#(
  parameter int Sample_size = FIR_SAMPLE_SIZE,
  parameter int FIFO_depth  = 8,
  parameter int addr_size   = 3,
  parameter int Prime_level = 4,
  parameter int div_size    = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [Sample_size-1:0] in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   run,
  input  logic [div_size-1:0]    rate_div,
  output logic [Sample_size-1:0] Sample_out,
  output logic                   sample_strobe,
  output logic                   underrun,
  output logic [addr_size:0]     fifo_count
);

  localparam logic [addr_size:0] PRIME_CNT = (addr_size + 1)'(Prime_level);

  feeder_state_t          state;
  logic [div_size-1:0]    div_reg;
  logic [div_size-1:0]    div_cnt;
  logic [Sample_size-1:0] head;
  logic                   full;
  logic                   empty;
  logic                   strobe_due;
  logic                   push;
  logic                   pop;

  // Dropping run suppresses a strobe that would land on the same edge.
  assign strobe_due = (state == STREAM) && run && (div_cnt == div_reg);
  assign in_ready   = !full;
  assign push       = in_valid && in_ready;
  assign pop        = strobe_due && !empty;

  fir_feeder_fifo #(
    .Sample_size (Sample_size),
    .FIFO_depth  (FIFO_depth),
    .addr_size   (addr_size)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (in_data),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      div_reg       <= '0;
      div_cnt       <= '0;
      Sample_out    <= '0;
      sample_strobe <= 1'b0;
      underrun      <= 1'b0;
    end else begin
      sample_strobe <= 1'b0;
      case (state)
        IDLE: begin
          if (run) begin
            state    <= PRIME;
            div_reg  <= rate_div;
            underrun <= 1'b0;
          end
        end
        PRIME: begin
          if (!run) begin
            state <= IDLE;
          end else if (fifo_count >= PRIME_CNT) begin
            state   <= STREAM;
            div_cnt <= '0;
          end
        end
        STREAM: begin
          if (!run) begin
            state <= IDLE;
          end else if (strobe_due) begin
            div_cnt       <= '0;
            sample_strobe <= 1'b1;
            // An empty FIFO still strobes with zero so the FIR cadence never slips.
            Sample_out    <= empty ? '0 : head;
            if (empty) underrun <= 1'b1;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Directed bench for fir_sample_feeder with a sample scoreboard checked on every strobe.
module tb_fir_sample_feeder;

  logic       clock = 1'b0;
  logic       reset;
  logic [5:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       run;
  logic [3:0] rate_div;
  logic [5:0] Sample_out;
  logic       sample_strobe;
  logic       underrun;
  logic [3:0] fifo_count;

  int n_cmp = 0;
  int n_err = 0;
  int strobes = 0;
  logic [5:0] sb[$];

  fir_sample_feeder dut (
    .clock         (clock),
    .reset         (reset),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .run           (run),
    .rate_div      (rate_div),
    .Sample_out    (Sample_out),
    .sample_strobe (sample_strobe),
    .underrun      (underrun),
    .fifo_count    (fifo_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: accepted samples queue up; each strobe must carry the oldest one, or zero if none.
  logic       mon_pv;
  logic [5:0] mon_pd;
  logic       mon_rs;
  logic [5:0] mon_exp;
  always @(posedge clock) begin
    mon_pv = in_valid && in_ready;
    mon_pd = in_data;
    mon_rs = reset;
    #1;
    if (mon_rs) begin
      sb.delete();
    end else begin
      if (sample_strobe === 1'b1) begin
        strobes++;
        mon_exp = (sb.size() > 0) ? sb.pop_front() : 6'd0;
        chk("sample_out", 32'(Sample_out), 32'(mon_exp));
      end
      if (mon_pv) sb.push_back(mon_pd);
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic push(input logic [5:0] d);
    int i;
    in_valid = 1'b1;
    in_data  = d;
    for (i = 0; i < 50 && !in_ready; i++) tick();
    chk("push_accept", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_strobes(input int n, input int limit);
    int target;
    target = strobes + n;
    for (int i = 0; i < limit && strobes < target; i++) tick();
    chk("strobe_wait", 32'(strobes), 32'(target));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    reset    = 1'b1;
    in_data  = '0;
    in_valid = 1'b0;
    run      = 1'b0;
    rate_div = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("rst_sample_out", 32'(Sample_out), 32'd0);
    chk("rst_strobe", 32'(sample_strobe), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Prime and first-strobe latency with a 3-cycle period.
    rate_div = 4'd2;
    run = 1'b1;
    tick();
    for (int d = 1; d <= 4; d++) push(6'(d));
    chk("prime_count", 32'(fifo_count), 32'd4);
    s0 = strobes;
    tick();
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("cadence_div2", 32'(sample_strobe), 32'((k % 3) == 0));
    end
    run = 1'b0;
    tick();
    chk("prime_strobes", 32'(strobes - s0), 32'd4);
    chk("prime_drained", 32'(fifo_count), 32'd0);
    chk("prime_no_underrun", 32'(underrun), 32'd0);

    // Full boundary: ninth sample held off.
    for (int d = 0; d < 8; d++) push(6'(20 + d));
    chk("full_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    in_data  = 6'd28;
    tick();
    tick();
    tick();
    chk("full_count", 32'(fifo_count), 32'd8);
    chk("full_held", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    rate_div = 4'd0;
    run = 1'b1;
    tick();
    tick();
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("burst_strobe", 32'(sample_strobe), 32'd1);
    end
    run = 1'b0;
    chk("burst_count", 32'(fifo_count), 32'd0);
    chk("burst_in_ready", 32'(in_ready), 32'd1);
    tick();

    // Underrun: zero-stuffed strobes and sticky flag.
    for (int d = 10; d <= 13; d++) push(6'(d));
    run = 1'b1;
    tick();
    tick();
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk("ur_strobe", 32'(sample_strobe), 32'd1);
      chk("ur_flag", 32'(underrun), 32'(k >= 5));
    end
    run = 1'b0;
    tick();
    tick();
    chk("ur_sticky", 32'(underrun), 32'd1);
    chk("ur_idle_no_strobe", 32'(sample_strobe), 32'd0);
    run = 1'b1;
    tick();
    chk("ur_cleared", 32'(underrun), 32'd0);
    run = 1'b0;
    tick();

    // Simultaneous push/pop at one sample per clock; pointers wrap.
    for (int d = 30; d <= 33; d++) push(6'(d));
    run = 1'b1;
    tick();
    tick();
    tick();
    chk("pp_start_count", 32'(fifo_count), 32'd3);
    for (int k = 0; k < 20; k++) begin
      in_valid = 1'b1;
      in_data  = 6'(34 + k);
      tick();
      chk("pp_count", 32'(fifo_count), 32'd3);
    end
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    run = 1'b0;
    chk("pp_drained", 32'(fifo_count), 32'd0);
    tick();
    chk("pp_no_underrun", 32'(underrun), 32'd0);

    // Stop mid-stream, then resume with the oldest entry.
    rate_div = 4'd1;
    for (int d = 40; d <= 45; d++) push(6'(d));
    run = 1'b1;
    wait_strobes(3, 30);
    run = 1'b0;
    tick();
    chk("stop_count", 32'(fifo_count), 32'd3);
    s0 = strobes;
    repeat (5) tick();
    chk("stop_no_strobe", 32'(strobes), 32'(s0));
    chk("stop_retained", 32'(fifo_count), 32'd3);
    push(6'd46);
    run = 1'b1;
    wait_strobes(4, 30);
    run = 1'b0;
    tick();
    chk("resume_drained", 32'(fifo_count), 32'd0);

    // Reset mid-stream with five entries buffered.
    rate_div = 4'd15;
    for (int d = 50; d <= 54; d++) push(6'(d));
    run = 1'b1;
    tick();
    tick();
    tick();
    chk("pre_rst_count", 32'(fifo_count), 32'd5);
    reset = 1'b1;
    tick();
    chk("mid_rst_count", 32'(fifo_count), 32'd0);
    chk("mid_rst_sample_out", 32'(Sample_out), 32'd0);
    chk("mid_rst_strobe", 32'(sample_strobe), 32'd0);
    chk("mid_rst_underrun", 32'(underrun), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    reset = 1'b0;
    run = 1'b0;
    rate_div = 4'd0;
    tick();
    for (int d = 60; d <= 63; d++) push(6'(d));
    run = 1'b1;
    wait_strobes(4, 20);
    run = 1'b0;
    tick();
    chk("post_rst_drained", 32'(fifo_count), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
